ifu: RTL



---
 rtl/ifu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu : instruction fetch unit
//
// Owns the program counter (PC) and instruction register (IR). On an
// instruction-load request it fetches one 16-bit word from instruction memory
// over a req/valid handshake and latches it into the IR. When idle it applies
// the PC-select command: hold, increment, IR-relative branch or jump.
//
// Optional build macro: IFU_TIMEOUT_EN
//   defined   : a fetch watchdog aborts a fetch after TIMEOUT cycles without
//               valid and sets the sticky fetch_err_out flag
//   undefined : no watchdog; a fetch waits indefinitely, fetch_err_out = 0
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   il_in           instruction load request
//   ps_in[1:0]      PC select: 00 hold, 01 +1, 10 PC+offset, 11 jump to a_in
//   a_in[AW-1:0]    jump target
//   imem_req_out    memory read request (high for the whole fetch)
//   imem_addr_out   read address (= PC)
//   imem_rdata_in   read data
//   imem_valid_in   read data valid
//   ins_out         IR contents
//   pc_out          current PC
//   stall_out       fetch outstanding
//   fetch_err_out   sticky fetch timeout flag
// ---------------------------------------------------------------------------
module ifu #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          il_in,
    input  logic [1:0]    ps_in,
    input  logic [AW-1:0] a_in,
    output logic          imem_req_out,
    output logic [AW-1:0] imem_addr_out,
    input  logic [15:0]   imem_rdata_in,
    input  logic          imem_valid_in,
    output logic [15:0]   ins_out,
    output logic [AW-1:0] pc_out,
    output logic          stall_out,
    output logic          fetch_err_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic          timeout_hit;

    // Branch offset is a 6-bit two's-complement field split across the IR.
    logic [5:0]    br_off;
    logic [AW-1:0] br_off_ext;

    assign br_off     = {ir_q[8:6], ir_q[2:0]};
    assign br_off_ext = {{(AW-6){br_off[5]}}, br_off};

`ifdef IFU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_q, wd_d;
    logic          err_q, err_d;

    // Expiry fires on the edge that would bring the count to TIMEOUT;
    // valid on that same edge takes precedence.
    assign timeout_hit = (state_q == FETCH) && !imem_valid_in &&
                         (wd_q == CW'(TIMEOUT - 1));

    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (state_q == IDLE && il_in) begin
            wd_d = '0;
        end else if (state_q == FETCH && !imem_valid_in) begin
            wd_d = wd_q + 1'b1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign fetch_err_out = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign fetch_err_out  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                // A load request wins over any PC update in the same cycle.
                if (il_in) begin
                    state_d = FETCH;
                end else begin
                    case (ps_in)
                        2'b00: pc_d = pc_q;
                        2'b01: pc_d = pc_q + 1'b1;
                        2'b10: pc_d = pc_q + br_off_ext;
                        2'b11: pc_d = a_in;
                    endcase
                end
            end
            FETCH: begin
                if (imem_valid_in) begin
                    ir_d    = imem_rdata_in;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req_out  = (state_q == FETCH);
    assign stall_out     = (state_q == FETCH);
    assign imem_addr_out = pc_q;
    assign pc_out        = pc_q;
    assign ins_out       = ir_q;

endmodule
